ysyx_23060171_ifu: RTL and testbench
====================================

Name: ysyx_23060171_ifu

Overview:
Multi-cycle instruction fetch unit that replaces the combinational instruction memory port upstream of the core datapath. It holds the architectural PC and issues one read per instruction on a valid/ready read-address/read-data interface. It presents the fetched word to the decode/execute logic through a valid/ready handshake. On acceptance it loads the consumer-supplied next PC.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset
TIMEOUT, 255, maximum cycles in WAIT before a fetch is declared faulted; 0 disables the timeout

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
araddr  out  32  fetch address, word aligned
arvalid  out  1  fetch request valid
arready  in  1  memory accepts request
rdata  in  32  fetched word
rresp  in  2  response code; 2'b00 means OK, any other value is an error
rvalid  in  1  response valid
rready  out  1  IFU accepts response
inst  out  32  instruction to decode
inst_pc  out  32  PC of inst
inst_valid  out  1  inst/inst_pc/fetch_err valid
inst_ready  in  1  consumer accepts instruction
next_pc  in  32  PC to fetch next; sampled on inst handshake
fetch_err  out  2  00 none, 01 bus error, 10 misaligned PC, 11 timeout
perf_fetch  out  32  completed fetches (see Optional Feature)
perf_stall  out  32  cycles spent in REQ+WAIT (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=REQ, pc=RESET_PC, inst=0, inst_pc=0, fetch_err=0, inst_valid=0, rready=0, timeout counter=0, perf counters=0. arvalid=1 after release.
- States: REQ, WAIT, HOLD.
- REQ:
  - arvalid=1, araddr=pc, rready=0.
  - If pc[1:0]!=0: arvalid=0; go to HOLD next cycle with fetch_err=10, inst=0, inst_pc=pc.
  - On arvalid&&arready: go to WAIT and clear the timeout counter.
  - rvalid seen in REQ is ignored. Stale responses after reset are dropped.
- WAIT:
  - arvalid=0, rready=1.
  - On rvalid: latch inst=rdata and inst_pc=pc. Set fetch_err=00 if rresp==0, else fetch_err=01 and inst=0. Go to HOLD.
  - Without rvalid: increment the counter. When counter==TIMEOUT-1 and rvalid=0 (TIMEOUT!=0), go to HOLD with fetch_err=11, inst=0, inst_pc=pc.
  - rvalid wins over timeout in the same cycle.
- HOLD:
  - inst_valid=1. inst, inst_pc and fetch_err stay stable until handshake.
  - On inst_valid&&inst_ready: pc<=next_pc, go to REQ, inst_valid=0 next cycle.
  - next_pc is sampled only in the handshake cycle.
- Latency:
  - With arready and rvalid each asserted in the earliest cycle: request in cycle 0, response in cycle 1, inst_valid in cycle 2.
  - With inst_ready held high, back-to-back throughput is 1 instruction per 3 cycles.
- One outstanding request maximum. Never assert arvalid and rready in the same cycle.
- araddr is always pc with bits [1:0] zero when arvalid=1.
- Reset mid-WAIT or mid-HOLD: abandons the transaction immediately. Held instruction is discarded and pc returns to RESET_PC.
- next_pc wrap-around: 32'hFFFFFFFC is fetched normally. No overflow checks are performed.

Optional Feature:
- Macro: YSYX_23060171_IFU_PERF_EN.
- Defined:
  - perf_fetch increments on each inst handshake, including error cases.
  - perf_stall increments on each cycle in REQ or WAIT.
  - Both are 32-bit, wrap from 32'hFFFFFFFF to 0, and reset to 0.
- Undefined: perf_fetch and perf_stall are tied to 0 and no counter registers exist.

Test Plan:
- Reset release, memory returns arready=1 immediately and rvalid=1 one cycle later with rdata=32'h00000413, rresp=0, inst_ready=1 → araddr=32'h80000000. inst=32'h00000413 and inst_pc=32'h80000000 with inst_valid=1 in cycle 2. Next araddr equals next_pc=32'h80000004.
- Consumer holds inst_ready=0 for 5 cycles in HOLD, next_pc changes each cycle → inst/inst_pc stable, no new arvalid. pc loads only the next_pc value present in the handshake cycle.
- rresp=2'b10 with rdata=32'hDEADBEEF → fetch_err=01, inst=0. After handshake, fetching continues at next_pc.
- next_pc=32'h80000002 → no arvalid asserted. HOLD with fetch_err=10, inst_pc=32'h80000002.
- TIMEOUT=4, rvalid never asserted → fetch_err=11 after 4 WAIT cycles. Repeat with rvalid arriving in the 4th WAIT cycle → fetch_err=00 and rdata latched.
- Assert rst low during WAIT, then deliver rvalid=1 right after release → response ignored. arvalid=1, araddr=32'h80000000. With YSYX_23060171_IFU_PERF_EN, perf counters read 0 after reset and perf_fetch=3 after three handshakes.

Source files
------------

// File: rtl/ysyx_23060171_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_ifu -- multi-cycle instruction fetch unit
//
// Holds the architectural PC. Each instruction is fetched with one read on a
// valid/ready address/data bus. The fetched word goes to the consumer through
// a valid/ready handshake. On acceptance, the consumer-supplied next_pc
// becomes the new PC.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   araddr/arvalid/arready   read-address channel (word-aligned address)
//   rdata/rresp/rvalid/rready read-data channel (rresp != 0 means bus error)
//   inst/inst_pc/inst_valid/inst_ready  fetched instruction to the consumer
//   next_pc                  PC to fetch next, sampled on the inst handshake
//   fetch_err                00 none, 01 bus error, 10 misaligned, 11 timeout
//   perf_fetch/perf_stall    performance counters (optional)
//
// Optional feature: define YSYX_23060171_IFU_PERF_EN to build the performance
// counters. Without it, perf_fetch and perf_stall are tied to zero.
// ---------------------------------------------------------------------------
module ysyx_23060171_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] next_pc,
    output logic [1:0]  fetch_err,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Terminal count value. It is only meaningful when the timeout is enabled.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;
    logic [1:0]        err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= ERR_NONE;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        arvalid    = 1'b0;
        rready     = 1'b0;
        inst_valid = 1'b0;
        araddr     = {pc_q[31:2], 2'b00};

        case (state_q)
            S_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    // A misaligned PC never reaches the bus.
                    // Report it directly to the consumer.
                    state_d   = S_HOLD;
                    err_d     = ERR_MISALIGN;
                    inst_d    = '0;
                    inst_pc_d = pc_q;
                end else begin
                    arvalid = 1'b1;
                    if (arready) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                rready = 1'b1;
                // A response in the terminal cycle beats the timeout.
                if (rvalid) begin
                    state_d   = S_HOLD;
                    inst_pc_d = pc_q;
                    if (rresp == 2'b00) begin
                        err_d  = ERR_NONE;
                        inst_d = rdata;
                    end else begin
                        err_d  = ERR_BUS;
                        inst_d = '0;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = S_HOLD;
                    err_d     = ERR_TIMEOUT;
                    inst_d    = '0;
                    inst_pc_d = pc_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;
    assign fetch_err = err_q;

`ifdef YSYX_23060171_IFU_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        inst_hs;

    // Error completions count as fetches too.
    assign inst_hs = (state_q == S_HOLD) && inst_ready;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (inst_hs) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_fetch = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060171_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060171_ifu -- self-checking bench for ysyx_23060171_ifu
//
// Each fetch is modelled as one transaction. The transaction has these
// elements:
//   - an address-ready delay
//   - a response delay (a delay at or beyond TIMEOUT means no response)
//   - a response code and data word
//   - a consumer hold time
//   - a next PC
//
// The bench predicts the following from these rules:
//   - the PC sequence
//   - the delivered instruction and error code
//   - the performance counts
// It checks the bus and consumer outputs on every cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_23060171_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TIMEOUT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] next_pc;
    logic [1:0]  fetch_err;
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;

    ysyx_23060171_ifu #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .next_pc    (next_pc),
        .fetch_err  (fetch_err),
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] pc_m;
    int          fetch_m;
    int          stall_m;
    int          txn_no = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven and outputs are sampled at the falling edge.
    // Each step passes exactly one rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_perf();
`ifdef YSYX_23060171_IFU_PERF_EN
        check_val("perf_fetch", perf_fetch, 32'(fetch_m));
        check_val("perf_stall", perf_stall, 32'(stall_m));
`else
        check_val("perf_fetch_off", perf_fetch, 32'd0);
        check_val("perf_stall_off", perf_stall, 32'd0);
`endif
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b0;
        arready    = 1'b0;
        inst_ready = 1'b0;
        next_pc    = $urandom;
        // A stale response is in flight across reset.
        rvalid     = 1'b1;
        rdata      = $urandom;
        rresp      = 2'b00;
        for (int i = 0; i < n; i++) begin
            step();
            check_val("rst_inst_valid", inst_valid, 1'b0);
            check_val("rst_rready", rready, 1'b0);
            check_val("rst_inst", inst, 32'd0);
            check_val("rst_inst_pc", inst_pc, 32'd0);
            check_val("rst_fetch_err", fetch_err, 2'b00);
            check_val("rst_perf_fetch", perf_fetch, 32'd0);
            check_val("rst_perf_stall", perf_stall, 32'd0);
        end
        rst     = 1'b1;
        pc_m    = RESET_PC;
        fetch_m = 0;
        stall_m = 0;
    endtask

    // Called at a falling edge with the DUT expected in REQ.
    // Returns at a falling edge, one cycle after the consumer handshake.
    task automatic fetch_txn(input int ar_dly, input int r_dly, input logic [1:0] resp,
                             input logic [31:0] data, input int hold_dly,
                             input logic [31:0] npc);
        logic [31:0] exp_inst;
        logic [1:0]  exp_err;
        bit          done;
        check_perf();
        if (pc_m[1:0] != 2'b00) begin
            check_val("mis_arvalid", arvalid, 1'b0);
            check_val("mis_rready", rready, 1'b0);
            check_val("mis_inst_valid", inst_valid, 1'b0);
            arready = 1'($urandom);
            rvalid  = 1'($urandom);
            rdata   = $urandom;
            step();
            stall_m += 1;
            exp_inst = 32'd0;
            exp_err  = 2'b10;
        end else begin
            for (int i = 0; i <= ar_dly; i++) begin
                check_val("req_arvalid", arvalid, 1'b1);
                check_val("req_araddr", araddr, pc_m);
                check_val("req_rready", rready, 1'b0);
                check_val("req_inst_valid", inst_valid, 1'b0);
                arready = (i == ar_dly);
                // Responses seen while requesting must be ignored.
                rvalid  = (i == 0) ? 1'b1 : 1'($urandom);
                rdata   = $urandom;
                rresp   = 2'($urandom);
                step();
            end
            arready  = 1'b0;
            rvalid   = 1'b0;
            stall_m += ar_dly + 1;
            exp_inst = 32'd0;
            exp_err  = 2'b11;
            done     = 1'b0;
            for (int w = 0; w < TIMEOUT && !done; w++) begin
                check_val("wait_arvalid", arvalid, 1'b0);
                check_val("wait_rready", rready, 1'b1);
                check_val("wait_inst_valid", inst_valid, 1'b0);
                stall_m += 1;
                if (w == r_dly) begin
                    rvalid   = 1'b1;
                    rdata    = data;
                    rresp    = resp;
                    exp_err  = (resp == 2'b00) ? 2'b00 : 2'b01;
                    exp_inst = (resp == 2'b00) ? data : 32'd0;
                    done     = 1'b1;
                end
                step();
                rvalid = 1'b0;
            end
        end
        for (int h = 0; h <= hold_dly; h++) begin
            check_val("hold_inst_valid", inst_valid, 1'b1);
            check_val("hold_inst", inst, exp_inst);
            check_val("hold_inst_pc", inst_pc, pc_m);
            check_val("hold_fetch_err", fetch_err, exp_err);
            check_val("hold_arvalid", arvalid, 1'b0);
            check_val("hold_rready", rready, 1'b0);
            inst_ready = (h == hold_dly);
            next_pc    = (h == hold_dly) ? npc : $urandom;
            step();
        end
        inst_ready = 1'b0;
        next_pc    = $urandom;
        $display("txn %0d pc=%h err=%0d inst=%h next=%h", txn_no, pc_m, exp_err, exp_inst, npc);
        txn_no++;
        pc_m = npc;
        fetch_m++;
        check_val("post_inst_valid", inst_valid, 1'b0);
    endtask

    function automatic logic [31:0] rand_npc();
        int sel = $urandom_range(0, 9);
        logic [31:0] v = $urandom;
        if (sel == 0) return v | 32'd2;
        if (sel == 1) return 32'hFFFF_FFFC;
        return {v[31:2], 2'b00};
    endfunction

    initial begin
        logic [1:0] rsp;
        do_reset(3);

        // Zero-latency fetch at the reset PC, then a fetch at next_pc.
        fetch_txn(0, 0, 2'b00, 32'h0000_0413, 0, 32'h8000_0004);
        // The consumer stalls for 5 cycles while next_pc wanders.
        fetch_txn(1, 1, 2'b00, 32'h1234_5678, 5, 32'h8000_0100);
        // A bus error response.
        fetch_txn(0, 0, 2'b10, 32'hDEAD_BEEF, 1, 32'h8000_0002);
        // A misaligned PC; the fetch then continues at an aligned address.
        fetch_txn(0, 0, 2'b00, 32'h0, 2, 32'h8000_0200);
        // Timeout, then a response in the last allowed WAIT cycle.
        fetch_txn(0, TIMEOUT + 5, 2'b00, 32'h0, 0, 32'h8000_0204);
        fetch_txn(0, TIMEOUT - 1, 2'b00, 32'hCAFE_F00D, 0, 32'hFFFF_FFFC);
        // Wrap-around address.
        fetch_txn(2, 0, 2'b00, 32'h0BAD_F00D, 0, 32'h8000_0300);

        // Randomized fetches, with an occasional reset mid-WAIT or mid-HOLD.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 15) == 0 && pc_m[1:0] == 2'b00) begin
                arready = 1'b1;
                step();
                arready = 1'b0;
                check_val("mid_wait_rready", rready, 1'b1);
                if ($urandom_range(0, 1) == 1) begin
                    rvalid = 1'b1;
                    rdata  = $urandom;
                    rresp  = 2'b00;
                    step();
                    rvalid = 1'b0;
                    check_val("mid_hold_valid", inst_valid, 1'b1);
                end
                do_reset(2);
                check_val("after_rst_arvalid", arvalid, 1'b1);
                check_val("after_rst_araddr", araddr, RESET_PC);
            end
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fetch_txn($urandom_range(0, 3), $urandom_range(0, TIMEOUT + 1), rsp,
                      $urandom, $urandom_range(0, 3), rand_npc());
        end

        // Reset during WAIT with a stale response right after release.
        fetch_txn(0, 0, 2'b00, 32'h1111_1111, 0, 32'h8000_0400);
        if (pc_m[1:0] != 2'b00) fetch_txn(0, 0, 2'b00, 32'h0, 0, 32'h8000_0400);
        arready = 1'b1;
        step();
        arready = 1'b0;
        check_val("final_wait_rready", rready, 1'b1);
        do_reset(2);
        check_val("final_arvalid", arvalid, 1'b1);
        check_val("final_araddr", araddr, RESET_PC);
        check_perf();
        fetch_txn(0, 0, 2'b00, 32'h2222_2222, 0, 32'h8000_0004);
        fetch_txn(1, 2, 2'b01, 32'h3333_3333, 1, 32'h8000_0008);
        fetch_txn(0, 1, 2'b00, 32'h4444_4444, 0, 32'h8000_000C);
`ifdef YSYX_23060171_IFU_PERF_EN
        check_val("perf_three", perf_fetch, 32'd3);
`else
        check_val("perf_three_off", perf_fetch, 32'd0);
`endif
        check_perf();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global cycle bound; the stimulus is cycle-driven, so this is a backstop.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
